patch_scan_ctrl: RTL

//  Upstream sequencer for addr_gen. Walks every convolution patch position of a

---
 rtl/conv_pkg.sv | 54 +++++
 rtl/scan_pos_counter.sv | 55 +++++
 rtl/patch_scan_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the patch scan sequencer: FSM state encoding,
// legal patch sizes, default geometry and the patch-position count helper.
package conv_pkg;

    // Scan controller states, visited in order for every accepted start
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } scan_state_t;

    // Only odd patch sides with a well-defined centre are supported
    localparam logic [2:0] PATCH_3 = 3'd3;
    localparam logic [2:0] PATCH_5 = 3'd5;
    localparam logic [2:0] PATCH_7 = 3'd7;

    // Default row-group size and addr_gen pipeline depth
    localparam int KROWS_DEF = 8;
    localparam int DRAIN_DEF = 3;

    // Width of the row/column position counters and position counts
    localparam int POS_W = 9;

    // True when the patch side is one of the supported sizes
    function automatic logic is_legal_patch(input logic [2:0] patch);
        return (patch == PATCH_3) || (patch == PATCH_5) || (patch == PATCH_7);
    endfunction

    // Number of patch positions along one image dimension:
    // floor((dim - patch) / stride) + 1, using a 9-step restoring divider so
    // no general-purpose divide operator is needed. Only meaningful for a
    // legal configuration (stride != 0, patch <= dim).
    function automatic logic [POS_W-1:0] npos(input logic [POS_W-1:0] dim,
                                             input logic [2:0]       patch,
                                             input logic [2:0]       stride);
        logic [POS_W-1:0] num;
        logic [POS_W-1:0] quo;
        logic [POS_W:0]   rem;
        num = dim - {6'd0, patch};
        quo = '0;
        rem = '0;
        for (int i = POS_W - 1; i >= 0; i--) begin
            rem = {rem[POS_W-1:0], num[i]};
            if (rem >= {7'd0, stride}) begin
                rem    = rem - {7'd0, stride};
                quo[i] = 1'b1;
            end
        end
        return quo + 9'd1;
    endfunction

endpackage

// File: rtl/scan_pos_counter.sv
// Two-dimensional row/column position counter. Column runs fastest and wraps
// at nx-1, bumping the row. Exposes the next-state position so the owner can
// register outputs derived from it in the same cycle the counter updates.
module scan_pos_counter
    import conv_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    input  logic [POS_W-1:0] nx,
    input  logic [POS_W-1:0] ny,
    output logic [POS_W-1:0] r_next,
    output logic [POS_W-1:0] c_next,
    output logic             last
);

    logic [POS_W-1:0] r_q, r_d;
    logic [POS_W-1:0] c_q, c_d;
    logic             col_end;

    // Next position: clear has priority, otherwise step column then row
    always_comb begin
        r_d     = r_q;
        c_d     = c_q;
        col_end = (c_q == nx - 9'd1);
        last    = col_end && (r_q == ny - 9'd1);
        if (clear) begin
            r_d = '0;
            c_d = '0;
        end else if (advance) begin
            if (col_end) begin
                c_d = '0;
                r_d = r_q + 9'd1;
            end else begin
                c_d = c_q + 9'd1;
            end
        end
    end

    assign r_next = r_d;
    assign c_next = c_d;

    // Position registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
            c_q <= '0;
        end else begin
            r_q <= r_d;
            c_q <= c_d;
        end
    end

endmodule

// File: rtl/patch_scan_ctrl.sv
// Upstream sequencer for addr_gen. Validates a latched patch_size/stride,
// then walks every patch position of the image one step per done_rmu,
// waits for the addr_gen pipeline to drain and pulses frame_done.
// Start to first en is two cycles (CHECK is a single cycle, the divider is
// combinational). DRAIN must be at least 1.
module patch_scan_ctrl
    import conv_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 32,
    parameter int KROWS  = KROWS_DEF,
    parameter int DRAIN  = DRAIN_DEF,
    localparam int XW    = $clog2(WIDTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [2:0]    patch_size,
    input  logic [2:0]    stride,
    input  logic          done_rmu,
    output logic          en,
    output logic [5:0]    cycle_counts,
    output logic [2:0]    k,
    output logic [XW-1:0] xcor1,
    output logic          busy,
    output logic          frame_done,
    output logic          cfg_err
);

    scan_state_t state_q, state_d;

    logic [2:0]       psize_q, psize_d;
    logic [2:0]       stride_q, stride_d;
    logic [POS_W-1:0] nx_q, nx_d;
    logic [POS_W-1:0] ny_q, ny_d;
    logic [7:0]       drain_cnt_q, drain_cnt_d;

    logic             en_q, en_d;
    logic [5:0]       cc_q, cc_d;
    logic [2:0]       k_q, k_d;
    logic [XW-1:0]    xcor1_q, xcor1_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             cfg_err_q, cfg_err_d;

    logic             pos_clear;
    logic             pos_advance;
    logic [POS_W-1:0] r_next;
    logic [POS_W-1:0] c_next;
    logic             pos_last;
    logic             cfg_ok;
    logic [POS_W-1:0] row_group;

    scan_pos_counter u_pos (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (pos_clear),
        .advance (pos_advance),
        .nx      (nx_q),
        .ny      (ny_q),
        .r_next  (r_next),
        .c_next  (c_next),
        .last    (pos_last)
    );

    // Next-state, counter control and registered-output computation
    always_comb begin
        state_d      = state_q;
        psize_d      = psize_q;
        stride_d     = stride_q;
        nx_d         = nx_q;
        ny_d         = ny_q;
        drain_cnt_d  = drain_cnt_q;
        en_d         = en_q;
        cc_d         = cc_q;
        k_d          = k_q;
        xcor1_d      = xcor1_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        cfg_err_d    = 1'b0;
        pos_clear    = 1'b0;
        pos_advance  = 1'b0;

        cfg_ok = (stride_q != 3'd0) && is_legal_patch(psize_q) &&
                 ({6'd0, psize_q} <= 9'(WIDTH)) &&
                 ({6'd0, psize_q} <= 9'(HEIGHT));

        row_group = r_next / 9'(KROWS);

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    psize_d  = patch_size;
                    stride_d = stride;
                    busy_d   = 1'b1;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!cfg_ok) begin
                    cfg_err_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    nx_d      = npos(9'(WIDTH), psize_q, stride_q);
                    ny_d      = npos(9'(HEIGHT), psize_q, stride_q);
                    pos_clear = 1'b1;
                    en_d      = 1'b1;
                    xcor1_d   = XW'(1);
                    k_d       = 3'd0;
                    cc_d      = 6'd1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (done_rmu) begin
                    pos_advance = 1'b1;
                    if (pos_last) begin
                        en_d        = 1'b0;
                        xcor1_d     = '0;
                        k_d         = '0;
                        cc_d        = '0;
                        drain_cnt_d = '0;
                        state_d     = ST_DRAIN;
                    end else begin
                        xcor1_d = XW'(c_next + 9'd1);
                        k_d     = 3'(r_next % 9'(KROWS));
                        cc_d    = (row_group >= 9'd63) ? 6'd63 : 6'(row_group + 9'd1);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == 8'(DRAIN - 1)) begin
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = ST_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, configuration and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            psize_q      <= '0;
            stride_q     <= '0;
            nx_q         <= '0;
            ny_q         <= '0;
            drain_cnt_q  <= '0;
            en_q         <= 1'b0;
            cc_q         <= '0;
            k_q          <= '0;
            xcor1_q      <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            psize_q      <= psize_d;
            stride_q     <= stride_d;
            nx_q         <= nx_d;
            ny_q         <= ny_d;
            drain_cnt_q  <= drain_cnt_d;
            en_q         <= en_d;
            cc_q         <= cc_d;
            k_q          <= k_d;
            xcor1_q      <= xcor1_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign en           = en_q;
    assign cycle_counts = cc_q;
    assign k            = k_q;
    assign xcor1        = xcor1_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
    assign cfg_err      = cfg_err_q;

endmodule
